// File: rtl/mem_datos_vec_pkg.sv
// Shared constants, state encoding and counter helper for the vector MEM-stage data memory.
package mem_vec_pkg;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 2;
  localparam int ACC_CNT_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Access counter step; relies on natural modular wrap of the fixed-width sum.
  function automatic logic [ACC_CNT_W-1:0] acc_next(input logic [ACC_CNT_W-1:0] cnt,
                                                   input logic                  inc);
    logic [ACC_CNT_W-1:0] res;
    if (inc) begin
      res = cnt + 16'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction
endpackage

// File: rtl/mem_datos_vec_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface mem_datos_vec_if #(
  parameter int DATA_W = mem_vec_pkg::DATA_W
);
  import mem_vec_pkg::*;

  logic [31:0]           dir_mem;
  logic [DATA_W-1:0]     data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic                  clear_start;
  logic [DATA_W-1:0]     data_out;
  logic                  data_valid;
  logic                  busy;
  logic                  addr_err;
  logic [ACC_CNT_W-1:0]  acc_count;

  modport master (
    output dir_mem, data_in, wr_en, rd_en, clear_start,
    input  data_out, data_valid, busy, addr_err, acc_count
  );

  modport slave (
    input  dir_mem, data_in, wr_en, rd_en, clear_start,
    output data_out, data_valid, busy, addr_err, acc_count
  );
endinterface

// File: rtl/mem_datos_vec_ram_sp_256x32.sv
// Single-port array: synchronous write, registered (read-old) read on the shared address.
module ram_sp_256x32 import mem_vec_pkg::*; #(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_comb begin
    rdata_d = mem_q[addr];
  end

  // Array storage is deliberately left out of reset so a reset mid-clear keeps contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_datos_vec.sv
// MEM-stage data memory: request acceptance, range check, zero-fill FSM and 2-cycle read return.
module mem_datos_vec #(
  parameter int ADDR_W = mem_vec_pkg::ADDR_W,
  parameter int DATA_W = mem_vec_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_datos_vec_if.slave bus
);
  import mem_vec_pkg::*;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     clr_idx_q, clr_idx_d;
  logic                  addr_err_q, addr_err_d;
  logic [ACC_CNT_W-1:0]  acc_q, acc_d;
  logic                  rd1_q, rd1_d;
  logic                  byp1_q, byp1_d;
  logic                  oor1_q, oor1_d;
  logic [DATA_W-1:0]     byp_data1_q, byp_data1_d;
  logic                  rd2_q, rd2_d;
  logic [DATA_W-1:0]     data2_q, data2_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;

  logic                  busy_s, accept_s, in_range_s, start_clr_s;
  logic [ADDR_W-1:0]     idx_s;
  logic                  ram_we_s;
  logic [ADDR_W-1:0]     ram_addr_s;
  logic [DATA_W-1:0]     ram_wdata_s;
  logic [DATA_W-1:0]     ram_rdata_s;

  always_comb begin
    busy_s      = (state_q == ST_CLEAR);
    in_range_s  = ((bus.dir_mem >> ADDR_W) == 32'd0);
    idx_s       = bus.dir_mem[ADDR_W-1:0];
    accept_s    = (bus.rd_en | bus.wr_en) & ~busy_s & ~bus.clear_start;
    start_clr_s = bus.clear_start & ~busy_s;
  end

  // Clear sequencer: one zero write per cycle, leaves after the last index.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == '1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // The clear engine owns the single RAM port while busy.
  always_comb begin
    if (busy_s) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = clr_idx_q;
      ram_wdata_s = '0;
    end else begin
      ram_we_s    = accept_s & bus.wr_en & in_range_s;
      ram_addr_s  = idx_s;
      ram_wdata_s = bus.data_in;
    end
  end

  // RAM returns pre-write data, so same-cycle write data is carried alongside for write-first.
  always_comb begin
    acc_d = acc_next(acc_q, accept_s);
    if (start_clr_s) begin
      addr_err_d = 1'b0;
    end else if (accept_s & ~in_range_s) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_q;
    end
    rd1_d       = accept_s & bus.rd_en;
    byp1_d      = bus.wr_en & in_range_s;
    oor1_d      = ~in_range_s;
    byp_data1_d = bus.data_in;
    rd2_d       = rd1_q;
    if (oor1_q) begin
      data2_d = '0;
    end else if (byp1_q) begin
      data2_d = byp_data1_q;
    end else begin
      data2_d = ram_rdata_s;
    end
    data_valid_d = rd2_q;
    if (rd2_q) begin
      data_out_d = data2_q;
    end else begin
      data_out_d = data_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_idx_q    <= '0;
      addr_err_q   <= 1'b0;
      acc_q        <= '0;
      rd1_q        <= 1'b0;
      byp1_q       <= 1'b0;
      oor1_q       <= 1'b0;
      byp_data1_q  <= '0;
      rd2_q        <= 1'b0;
      data2_q      <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      addr_err_q   <= addr_err_d;
      acc_q        <= acc_d;
      rd1_q        <= rd1_d;
      byp1_q       <= byp1_d;
      oor1_q       <= oor1_d;
      byp_data1_q  <= byp_data1_d;
      rd2_q        <= rd2_d;
      data2_q      <= data2_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  ram_sp_256x32 #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign bus.busy       = busy_s;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.acc_count  = acc_q;
endmodule

// File: tb/tb_mem_datos_vec.sv
// Randomised scoreboard bench for mem_datos_vec against a plain-array reference memory.
module tb_mem_datos_vec;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_datos_vec_if bus ();
  mem_datos_vec dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mem_m [256];
  int          acc_m = 0;
  logic        err_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One accepted request; the reference memory resolves it with write-first semantics.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit in_r;
    bus.rd_en = rd; bus.wr_en = wr; bus.dir_mem = a; bus.data_in = d; bus.clear_start = 1'b0;
    @(posedge clk);
    in_r  = ((a >> 8) == 32'd0);
    acc_m = (acc_m + 1) % 65536;
    if (!in_r) err_m = 1'b1;
    if (rd) exp_q.push_back(!in_r ? 32'd0 : (wr ? d : mem_m[a[7:0]]));
    if (wr && in_r) mem_m[a[7:0]] = d;
    #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_acc"}, {16'd0, bus.acc_count}, acc_m[31:0]);
    chk({tag, "_err"}, {31'd0, bus.addr_err}, {31'd0, err_m});
  endtask

  // Monitor: every data_valid strobe consumes one expected read result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", {31'd0, bus.data_valid}, 32'd0);
      else                   chk("rd_data", bus.data_out, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          n;
    int          op;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.dir_mem = 32'd0; bus.data_in = 32'd0;
    bus.clear_start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", bus.data_out, 32'd0);
    chk("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_status("rst");
    rst_n = 1'b1;
    idle(1);

    // Write then read back with explicit latency check.
    do_req(1'b0, 1'b1, 32'h05, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h05, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("lat_not_yet", {31'd0, bus.data_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, bus.data_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("wr_rd_acc", {16'd0, bus.acc_count}, 32'd2);

    for (int i = 0; i < 256; i++) do_req(1'b0, 1'b1, i, $urandom | 32'd1);
    check_status("fill");

    do_req(1'b1, 1'b1, 32'h10, 32'h12345678);
    check_status("rdwr");
    do_req(1'b1, 1'b0, 32'h100, 32'h0);
    check_status("oor_rd");
    do_req(1'b0, 1'b1, 32'h1FF, 32'hBAD0BAD0);
    do_req(1'b1, 1'b0, 32'hFF, 32'h0);
    check_status("oor_wr");

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 4);
      a  = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & 32'hFF;
      else if ((a >> 8) == 32'd0) a = a | 32'h100;
      if (op == 0) idle(1);
      else do_req(op[0] | (op == 4), op[1] | (op == 4), a, $urandom);
      check_status("rand");
    end

    for (int i = 0; i < 256; i++) do_req(1'b0, 1'b1, i, $urandom | 32'd1);
    idle(4);

    // In-flight read before clear, then clear with rd_en held throughout.
    do_req(1'b1, 1'b0, 32'h80, 32'h0);
    bus.clear_start = 1'b1; bus.rd_en = 1'b1; bus.dir_mem = 32'h3;
    @(posedge clk);
    err_m = 1'b0;
    #1;
    bus.clear_start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      n++;
      @(posedge clk);
      #1;
    end
    bus.rd_en = 1'b0;
    chk("busy_cycles", n, 32'd256);
    for (int i = 0; i < 256; i++) mem_m[i] = 32'd0;
    check_status("post_clear");
    do_req(1'b1, 1'b0, 32'h00, 32'h0);
    do_req(1'b1, 1'b0, 32'h80, 32'h0);
    do_req(1'b1, 1'b0, 32'hFF, 32'h0);
    check_status("clear_rd");

    // Reset aborts a clear at index 0x40; upper half keeps its data.
    do_req(1'b0, 1'b1, 32'h7F, 32'hCAFE0001);
    do_req(1'b0, 1'b1, 32'h20, 32'h5A5A5A5A);
    do_req(1'b1, 1'b0, 32'h7F, 32'h0);
    idle(4);
    bus.clear_start = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_start = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_data", bus.data_out, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.data_valid}, 32'd0);
    acc_m = 0; err_m = 1'b0;
    check_status("mid_rst");
    for (int i = 0; i < 64; i++) mem_m[i] = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    do_req(1'b1, 1'b0, 32'h7F, 32'h0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0);
    do_req(1'b1, 1'b0, 32'h40, 32'h0);
    idle(4);

    while (acc_m != 65535) do_req(1'b0, 1'b1, 32'h01, $urandom);
    chk("acc_ffff", {16'd0, bus.acc_count}, 32'h0000FFFF);
    do_req(1'b0, 1'b1, 32'h02, 32'h1);
    chk("acc_wrap", {16'd0, bus.acc_count}, 32'h0);
    idle(4);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_datos_vec.md
# mem_datos_vec

Data-memory responder for the vector pipeline's MEM stage. Accepts the stage's word address, write data and read/write strobes, and serves them from a 256×32 synchronous array. Reads return after a fixed 2-cycle latency. A hardware clear sequence zeroes the whole array, and the block keeps an access counter and a sticky address-error flag. It sits between the MEM stage (the initiator) and the MEM/WB register; reads return on `data_out`.

## Interface
- `ADDR_W`, default 8: array index width (depth = 2^ADDR_W).
- `DATA_W`, default 32: word width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `dir_mem` in 32: word address from the MEM stage.
- `data_in` in DATA_W: write data from the MEM stage.
- `wr_en` in 1: write request.
- `rd_en` in 1: read request.
- `clear_start` in 1: start the zero-fill of the whole array.
- `data_out` out DATA_W: read data.
- `data_valid` out 1: one-cycle strobe qualifying `data_out`.
- `busy` out 1: clear in progress; requests are ignored.
- `addr_err` out 1: sticky flag; an out-of-range access occurred.
- `acc_count` out 16: number of accepted accesses; wraps.

## Operation
- **Reset** (`rst_n`=0, asynchronous):
  - state=IDLE, clear index=0.
  - `data_out`=0, `data_valid`=0, `busy`=0, `addr_err`=0, `acc_count`=0.
  - The read pipeline is flushed.
  - Array contents are not reset.
- **Acceptance.** A request is accepted in a cycle when (`rd_en`|`wr_en`) & !`busy` & !`clear_start`. Requests that are not accepted are dropped and not counted; the initiator must hold them.
- **Range check.** An address is in range iff `dir_mem[31:ADDR_W]`==0. The index is `dir_mem[ADDR_W-1:0]`.
- **Write.** An accepted in-range write updates the array at the acceptance edge. An out-of-range write is discarded and sets `addr_err`.
- **Read.** An accepted read enters a 2-stage pipeline. An out-of-range read returns 0, still pulses `data_valid`, and sets `addr_err`.
- **Simultaneous read and write.** `rd_en`&`wr_en` in the same cycle is one access (count +1). It behaves as write-first: the read returns `data_in`.
- **Counting.** `acc_count` increments by 1 per accepted cycle and wraps 0xFFFF→0x0000.
- **State machine:**
  - IDLE→CLEAR on `clear_start` while not busy. Clear index=0, `addr_err` cleared.
  - CLEAR writes 0 to the index each cycle and increments it.
  - CLEAR→IDLE after index 2^ADDR_W−1 is written.
  - `clear_start` during CLEAR is ignored.
- **Reads already in flight at clear start** complete normally with the pre-clear data.
- **Reset mid-clear** aborts the clear. Partially cleared contents remain.

## Timing
- Read accepted at edge N: `data_out`/`data_valid` are valid in the cycle after edge N+2. That is latency 2, back-to-back throughput of 1 per cycle, and `data_valid` high 1 cycle per read.
- Write accepted at edge N is visible to a read accepted at edge N+1. Same-cycle read+write is bypassed.
- `data_out` holds its last value while `data_valid`=0.
- Clear:
  - `clear_start` sampled at edge N.
  - `busy`=1 for cycles N+1..N+256, which is 256 cycles at the default depth.
  - `busy`=0 from the cycle after edge N+256.
  - The first request can be accepted at edge N+257.
- `busy` is decoded from the state register and is glitch-free relative to `clk`.

## Structure
- Package `mem_vec_pkg`:
  - `ADDR_W`, `DATA_W`, `RD_LAT`=2.
  - State enum {IDLE, CLEAR}.
  - `ACC_CNT_W`=16.
- Sub-module `ram_sp_256x32`:
  - Single-port array with synchronous write and registered read.
  - Port muxing between the clear engine and the request path is done in the top module.
- The top module contains the FSM, the clear index counter, the range check, the bypass register, the output stage, and the counters.

## Test plan
- **Write/read:** write 0xDEADBEEF @0x05, then read @0x05 the next cycle → `data_out`=0xDEADBEEF with `data_valid` two edges after the read is accepted; `acc_count`=2.
- **Same-cycle read+write:** `rd_en`=`wr_en`=1 @0x10 with `data_in`=0x12345678 → read returns 0x12345678; `acc_count` +1.
- **Out of range:** read @0x100 → `data_out`=0, `data_valid`=1, `addr_err`=1. Write @0x1FF → array @0xFF unchanged.
- **Clear:**
  - Fill 0x00..0xFF with nonzero data, then pulse `clear_start` → `busy` high for exactly 256 cycles.
  - `rd_en` held during `busy` is not counted.
  - Afterwards reads of 0x00, 0x80, 0xFF return 0 and `addr_err`=0.
- **Reset/wrap:**
  - Assert `rst_n`=0 at clear index 0x40 → all outputs 0 immediately; after release, @0x7F still holds its old data.
  - Preload `acc_count` to 0xFFFF via 65535 accesses, then one more access → 0x0000.
